// File: rtl/regfile_mcycle_wb_arbiter.sv
// Arbitrates the register file's second write port between the MCycle unit
// and the main pipeline writeback. Pipeline writeback (WE3) always wins;
// MCycle results wait in a small circular FIFO and drain into idle cycles.
// Queued entries that a younger pipeline write targets are squashed so that
// the stale MCycle value can never overwrite the newer register contents.
module regfile_mcycle_wb_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      WE3,
  input  logic [3:0]                A3,
  input  logic                      MC_VALID,
  output logic                      MC_READY,
  input  logic [3:0]                MC_WA,
  input  logic [31:0]               MC_WD,
  output logic                      MCycle_WE3,
  output logic [3:0]                MCycle_WA3,
  output logic [31:0]               MCycle_WD3,
  input  logic [3:0]                A1,
  input  logic [3:0]                A2,
  output logic                      HAZ1,
  output logic                      HAZ2,
  output logic [$clog2(DEPTH):0]    PEND_CNT,
  output logic                      R15_ERR
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [3:0] RegPc = 4'd15;

  // Slot storage: live bit is reset, payload is plain datapath storage
  logic [DEPTH-1:0] slot_live;
  logic [DEPTH-1:0] live_next;
  logic [3:0]       slot_wa [DEPTH];
  logic [31:0]      slot_wd [DEPTH];

  logic [PtrW-1:0]  head;
  logic [PtrW-1:0]  tail;
  logic [CntW-1:0]  cnt;
  logic             r15_err;

  logic             empty;
  logic             full;
  logic             head_live;
  logic             enq;
  logic             pop;
  logic [DEPTH-1:0] squash;
  logic             hit1;
  logic             hit2;

  assign empty     = (cnt == '0);
  assign full      = (cnt == DepthCnt);
  assign head_live = slot_live[head];

  // Ready is purely from registered occupancy; a same-cycle pop does not help
  assign MC_READY = RESET_N && !full;
  assign enq      = MC_VALID && MC_READY;

  // A dead (squashed or R15) head leaves without using the write port
  assign pop = !empty && (!WE3 || !head_live);

  // Drain the head into the write port whenever the pipeline is not writing
  assign MCycle_WE3 = RESET_N && !empty && !WE3 && head_live;
  assign MCycle_WA3 = empty ? 4'd0  : slot_wa[head];
  assign MCycle_WD3 = empty ? 32'd0 : slot_wd[head];

  assign PEND_CNT = cnt;
  assign R15_ERR  = r15_err;

  // Squash mask: stored live slots that the current pipeline write supersedes
  always_comb begin
    squash = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash[i] = WE3 && slot_live[i] && (slot_wa[i] == A3);
    end
  end

  // Next live bits: squash, retire the popped head, install the new tail
  always_comb begin
    live_next = slot_live & ~squash;
    if (pop) begin
      live_next[head] = 1'b0;
    end
    // Tail slot is free whenever enq is possible, so it never collides with pop
    if (enq) begin
      live_next[tail] = (MC_WA != RegPc);
    end
  end

  // Source-register hazard search over stored live slots
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_live[i] && (slot_wa[i] == A1)) begin
        hit1 = 1'b1;
      end
      if (slot_live[i] && (slot_wa[i] == A2)) begin
        hit2 = 1'b1;
      end
    end
  end

  // An accepting result counts as pending in the same cycle
  assign HAZ1 = (A1 != RegPc) && (hit1 || (enq && (MC_WA == A1)));
  assign HAZ2 = (A2 != RegPc) && (hit2 || (enq && (MC_WA == A2)));

  // Control state: pointers, occupancy, live bits and the sticky R15 flag
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      slot_live <= '0;
      r15_err   <= 1'b0;
    end else begin
      slot_live <= live_next;
      if (enq) begin
        tail <= tail + PtrW'(1);
      end
      if (pop) begin
        head <= head + PtrW'(1);
      end
      unique case ({enq, pop})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
      if (enq && (MC_WA == RegPc)) begin
        r15_err <= 1'b1;
      end
    end
  end

  // Payload write; contents are don't-care until the live/occupancy state says otherwise
  always_ff @(posedge CLK) begin
    if (enq) begin
      slot_wa[tail] <= MC_WA;
      slot_wd[tail] <= MC_WD;
    end
  end

endmodule

// File: tb/tb_regfile_mcycle_wb_arbiter.sv
// Directed bench for regfile_mcycle_wb_arbiter. Expected register-file writes
// are queued as stimulus is issued; a monitor pops and compares on each
// MCycle_WE3 pulse and flags any write that was not expected.
module tb_regfile_mcycle_wb_arbiter;

  logic        CLK;
  logic        RESET_N;
  logic        WE3;
  logic [3:0]  A3;
  logic        MC_VALID;
  logic        MC_READY;
  logic [3:0]  MC_WA;
  logic [31:0] MC_WD;
  logic        MCycle_WE3;
  logic [3:0]  MCycle_WA3;
  logic [31:0] MCycle_WD3;
  logic [3:0]  A1;
  logic [3:0]  A2;
  logic        HAZ1;
  logic        HAZ2;
  logic [1:0]  PEND_CNT;
  logic        R15_ERR;

  int total = 0;
  int bad   = 0;
  logic [35:0] exp_q[$];

  regfile_mcycle_wb_arbiter #(.DEPTH(2)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .WE3        (WE3),
    .A3         (A3),
    .MC_VALID   (MC_VALID),
    .MC_READY   (MC_READY),
    .MC_WA      (MC_WA),
    .MC_WD      (MC_WD),
    .MCycle_WE3 (MCycle_WE3),
    .MCycle_WA3 (MCycle_WA3),
    .MCycle_WD3 (MCycle_WD3),
    .A1         (A1),
    .A2         (A2),
    .HAZ1       (HAZ1),
    .HAZ2       (HAZ2),
    .PEND_CNT   (PEND_CNT),
    .R15_ERR    (R15_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic mc(input logic v, input logic [3:0] wa, input logic [31:0] wd);
    MC_VALID = v;
    MC_WA    = wa;
    MC_WD    = wd;
  endtask

  // Monitor: every write to the register file must match the oldest expectation
  always @(negedge CLK) begin
    if (MCycle_WE3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got wa=%0d wd=%0h expected no write",
                 MCycle_WA3, MCycle_WD3);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        chk("write_wa", {28'd0, MCycle_WA3}, {28'd0, e[35:32]});
        chk("write_wd", MCycle_WD3, e[31:0]);
      end
    end
  end

  initial begin
    RESET_N = 1'b0;
    WE3 = 1'b0;
    A3 = 4'd0;
    A1 = 4'd0;
    A2 = 4'd0;
    mc(1'b0, 4'd0, 32'd0);

    // Reset state
    cyc();
    cyc();
    smp();
    chk("rst_pend", 32'(PEND_CNT), 32'd0);
    chk("rst_ready", 32'(MC_READY), 32'd0);
    chk("rst_r15", 32'(R15_ERR), 32'd0);
    chk("rst_we", 32'(MCycle_WE3), 32'd0);
    chk("rst_wa", 32'(MCycle_WA3), 32'd0);
    chk("rst_wd", MCycle_WD3, 32'd0);
    cyc();
    RESET_N = 1'b1;
    smp();
    chk("rel_ready", 32'(MC_READY), 32'd1);

    // 1: minimum latency
    cyc();
    mc(1'b1, 4'd3, 32'hDEADBEEF);
    exp_q.push_back({4'd3, 32'hDEADBEEF});
    smp();
    chk("t1_ready", 32'(MC_READY), 32'd1);
    chk("t1_we_before", 32'(MCycle_WE3), 32'd0);
    cyc();
    mc(1'b0, 4'd0, 32'd0);
    smp();
    chk("t1_we", 32'(MCycle_WE3), 32'd1);
    chk("t1_pend1", 32'(PEND_CNT), 32'd1);
    cyc();
    smp();
    chk("t1_pend0", 32'(PEND_CNT), 32'd0);
    chk("t1_we_after", 32'(MCycle_WE3), 32'd0);

    // 2: fill while pipeline owns the port, third result held off
    cyc();
    WE3 = 1'b1;
    A3 = 4'd7;
    mc(1'b1, 4'd4, 32'h11);
    exp_q.push_back({4'd4, 32'h11});
    cyc();
    mc(1'b1, 4'd5, 32'h22);
    exp_q.push_back({4'd5, 32'h22});
    smp();
    chk("t2_ready1", 32'(MC_READY), 32'd1);
    cyc();
    mc(1'b1, 4'd8, 32'h99);
    smp();
    chk("t2_full_ready", 32'(MC_READY), 32'd0);
    chk("t2_full_pend", 32'(PEND_CNT), 32'd2);
    chk("t2_we_blocked", 32'(MCycle_WE3), 32'd0);
    cyc();
    smp();
    chk("t2_still_full", 32'(PEND_CNT), 32'd2);
    cyc();
    WE3 = 1'b0;
    smp();
    chk("t2_full_pop_ready", 32'(MC_READY), 32'd0);
    cyc();
    mc(1'b0, 4'd0, 32'd0);
    smp();
    chk("t2_ready_after_pop", 32'(MC_READY), 32'd1);
    chk("t2_pend1", 32'(PEND_CNT), 32'd1);
    cyc();
    smp();
    chk("t2_pend0", 32'(PEND_CNT), 32'd0);

    // 3: squash by a younger pipeline write
    cyc();
    WE3 = 1'b1;
    A3 = 4'd2;
    mc(1'b1, 4'd6, 32'h33);
    cyc();
    mc(1'b0, 4'd0, 32'd0);
    A3 = 4'd6;
    smp();
    chk("t3_pend_q", 32'(PEND_CNT), 32'd1);
    cyc();
    WE3 = 1'b0;
    smp();
    chk("t3_dead_pend", 32'(PEND_CNT), 32'd1);
    chk("t3_dead_we", 32'(MCycle_WE3), 32'd0);
    cyc();
    smp();
    chk("t3_pend0", 32'(PEND_CNT), 32'd0);

    // 4: hazard flags
    cyc();
    WE3 = 1'b1;
    A3 = 4'd7;
    A1 = 4'd9;
    A2 = 4'd15;
    mc(1'b1, 4'd9, 32'h99);
    exp_q.push_back({4'd9, 32'h99});
    smp();
    chk("t4_haz1_enq", 32'(HAZ1), 32'd1);
    chk("t4_haz2_enq", 32'(HAZ2), 32'd0);
    cyc();
    mc(1'b0, 4'd0, 32'd0);
    smp();
    chk("t4_haz1_q", 32'(HAZ1), 32'd1);
    chk("t4_haz2_q", 32'(HAZ2), 32'd0);
    chk("t4_pend", 32'(PEND_CNT), 32'd1);
    cyc();
    WE3 = 1'b0;
    smp();
    chk("t4_haz1_wr", 32'(HAZ1), 32'd1);
    cyc();
    smp();
    chk("t4_haz1_done", 32'(HAZ1), 32'd0);
    chk("t4_pend0", 32'(PEND_CNT), 32'd0);

    // 5: R15 target is dropped and flagged
    cyc();
    A1 = 4'd15;
    A2 = 4'd3;
    mc(1'b1, 4'd15, 32'h55);
    smp();
    chk("t5_haz1", 32'(HAZ1), 32'd0);
    chk("t5_r15_pre", 32'(R15_ERR), 32'd0);
    cyc();
    mc(1'b0, 4'd0, 32'd0);
    smp();
    chk("t5_r15", 32'(R15_ERR), 32'd1);
    chk("t5_pend1", 32'(PEND_CNT), 32'd1);
    chk("t5_we", 32'(MCycle_WE3), 32'd0);
    cyc();
    smp();
    chk("t5_pend0", 32'(PEND_CNT), 32'd0);
    chk("t5_r15_sticky", 32'(R15_ERR), 32'd1);

    // 6: reset discards queued results
    cyc();
    WE3 = 1'b1;
    A3 = 4'd7;
    A1 = 4'd10;
    A2 = 4'd11;
    mc(1'b1, 4'd10, 32'hA);
    cyc();
    mc(1'b1, 4'd11, 32'hB);
    cyc();
    mc(1'b0, 4'd0, 32'd0);
    smp();
    chk("t6_pend2", 32'(PEND_CNT), 32'd2);
    chk("t6_haz1", 32'(HAZ1), 32'd1);
    chk("t6_haz2", 32'(HAZ2), 32'd1);
    cyc();
    RESET_N = 1'b0;
    smp();
    chk("t6_ready_rst", 32'(MC_READY), 32'd0);
    cyc();
    RESET_N = 1'b1;
    WE3 = 1'b0;
    smp();
    chk("t6_pend0", 32'(PEND_CNT), 32'd0);
    chk("t6_haz1_clr", 32'(HAZ1), 32'd0);
    chk("t6_haz2_clr", 32'(HAZ2), 32'd0);
    chk("t6_r15_clr", 32'(R15_ERR), 32'd0);
    chk("t6_ready", 32'(MC_READY), 32'd1);
    chk("t6_we", 32'(MCycle_WE3), 32'd0);
    repeat (3) cyc();
    smp();
    chk("all_writes_seen", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
